// File: rtl/jam_pkg.sv
// Widths and state encoding shared by the cost table and the assignment engine,
// so both ends of the W/J/Cost interface agree.
package jam_pkg;

    localparam int JAM_ADDR_W    = 3;
    localparam int JAM_IDX_W     = 2 * JAM_ADDR_W;
    localparam int JAM_COST_W    = 7;
    localparam int JAM_MINCOST_W = 10;
    localparam int JAM_COUNT_W   = 4;
    localparam int JAM_N_ENTRIES = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } jam_state_t;

endpackage

// File: rtl/jam_cost_mem.sv
// 64-entry cost register array: synchronous write, combinational read,
// asynchronous clear so a reset mid-load leaves no stale costs behind.
module jam_cost_mem
    import jam_pkg::*;
#(
    parameter int COST_WIDTH = JAM_COST_W,
    parameter int N_ENTRIES  = JAM_N_ENTRIES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic [JAM_IDX_W-1:0]  waddr,
    input  logic [COST_WIDTH-1:0] wdata,
    input  logic [JAM_IDX_W-1:0]  raddr,
    output logic [COST_WIDTH-1:0] rdata
);

    logic [COST_WIDTH-1:0] mem [N_ENTRIES];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_table.sv
// Cost-matrix responder for the assignment engine: loads the 8x8 matrix from the
// host, releases the engine while serving Cost, and captures its result.
module jam_cost_table
    import jam_pkg::*;
#(
    parameter int COST_WIDTH = JAM_COST_W,
    parameter int CYC_WIDTH  = 20,
    parameter int N_ENTRIES  = JAM_N_ENTRIES
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [COST_WIDTH-1:0]    load_data,
    output logic                     load_ready,
    input  logic [JAM_ADDR_W-1:0]    W,
    input  logic [JAM_ADDR_W-1:0]    J,
    output logic [COST_WIDTH-1:0]    Cost,
    output logic                     jam_rst,
    input  logic                     Valid,
    input  logic [JAM_MINCOST_W-1:0] MinCost,
    input  logic [JAM_COUNT_W-1:0]   MatchCount,
    output logic                     done,
    output logic [JAM_MINCOST_W-1:0] res_cost,
    output logic [JAM_COUNT_W-1:0]   res_count,
    output logic [CYC_WIDTH-1:0]     solve_cycles
);

    jam_state_t           state;
    logic [JAM_IDX_W-1:0] load_idx;
    logic                 load_we;

    assign load_we = load_valid & load_ready;

    jam_cost_mem #(
        .COST_WIDTH (COST_WIDTH),
        .N_ENTRIES  (N_ENTRIES)
    ) u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (load_we),
        .waddr (load_idx),
        .wdata (load_data),
        .raddr ({W, J}),
        .rdata (Cost)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= EMPTY;
            load_idx     <= '0;
            load_ready   <= 1'b0;
            jam_rst      <= 1'b1;
            done         <= 1'b0;
            res_cost     <= '0;
            res_count    <= '0;
            solve_cycles <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load_start) begin
                        state        <= LOAD;
                        load_idx     <= '0;
                        load_ready   <= 1'b1;
                        solve_cycles <= '0;
                    end
                end
                LOAD: begin
                    if (load_we) begin
                        // Index is exactly 6 bits, so the last accept wraps it to 0.
                        load_idx <= load_idx + 1'b1;
                        if (load_idx == JAM_IDX_W'(N_ENTRIES - 1)) begin
                            state      <= SERVE;
                            load_ready <= 1'b0;
                            jam_rst    <= 1'b0;
                        end
                    end
                end
                SERVE: begin
                    if (solve_cycles != '1) begin
                        solve_cycles <= solve_cycles + 1'b1;
                    end
                    if (Valid) begin
                        state     <= DONE;
                        res_cost  <= MinCost;
                        res_count <= MatchCount;
                        done      <= 1'b1;
                        jam_rst   <= 1'b1;
                    end
                end
                DONE: begin
                    // Results stay visible until the next capture, not the next load.
                    if (load_start) begin
                        state        <= LOAD;
                        load_idx     <= '0;
                        load_ready   <= 1'b1;
                        done         <= 1'b0;
                        solve_cycles <= '0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
